regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 The block SHALL take parameter NUM_RD, default 4, number of read ports.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports we0 / wa0 / wd0, input, 1 / ADDR_W / DATA_W, write port 0 enable, address and data.
REQ-008 The block SHALL have ports we1 / wa1 / wd1, input, 1 / ADDR_W / DATA_W, write port 1 enable, address and data.
REQ-009 The block SHALL have port re, input, NUM_RD, per-read-port enable.
REQ-010 The block SHALL have port ra, input, NUM_RD*ADDR_W, flattened read addresses; port i at [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd, output, NUM_RD*DATA_W, flattened read data; port i at [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have port rv, output, NUM_RD, per-port read-valid (operand ready, not pending).
REQ-013 The block SHALL have ports rsv_en / rsv_addr, input, 1 / ADDR_W, reserve request: mark destination register pending.
REQ-014 The block SHALL have port clr_req, input, 1, single-cycle request to start a clear sweep.
REQ-015 The block SHALL have port busy, output, 1, registered; high while a clear sweep runs.

Function
REQ-016 Writes SHALL occur on the rising clk edge when the enable is high; address 0 is never written.
REQ-017 When we0 and we1 target the same address in the same cycle, port 1 SHALL win.
REQ-018 Reads SHALL be combinational, evaluated per port i in this priority:
- rst low: rd=0, rv=0.
- busy high: rd=0, rv=0.
- re[i]=0: rd=0, rv=0.
- ra_i=0: rd=0, rv=1.
- ra_i matches an active port-1 write: rd=wd1, rv=1.
- ra_i matches an active port-0 write: rd=wd0, rv=1.
- otherwise: rd=regs[ra_i], rv = ~pending[ra_i].
REQ-019 A pending bit per register SHALL be set on the edge where rsv_en is high with rsv_addr != 0; rsv_addr = 0 is ignored.
REQ-020 A pending bit SHALL clear on the edge where either write port writes that address.
REQ-021 When a reserve and a write hit the same address in the same cycle, the write data SHALL be stored and pending SHALL end set (reserve wins).
REQ-022 The sweep FSM SHALL have two states, IDLE and SWEEP, with a pointer ptr of ADDR_W bits.
REQ-023 In IDLE, clr_req high SHALL set ptr=1, move to SWEEP and assert busy from the next cycle.
REQ-024 Each SWEEP cycle SHALL zero regs[ptr], clear pending[ptr] and increment ptr.
REQ-025 On the edge that clears ptr = 2**ADDR_W-1, the FSM SHALL return to IDLE and drop busy; busy therefore stays high exactly 2**ADDR_W-1 cycles.
REQ-026 In SWEEP, write ports, reserve requests and further clr_req SHALL be ignored.
REQ-027 In IDLE, writes and reserves in the same cycle as clr_req SHALL take effect on that edge; the sweep overwrites them afterwards.
REQ-028 Behaviour SHALL be correct for any DATA_W >= 1, ADDR_W >= 1 and NUM_RD >= 1.

Reset
REQ-029 While rst is low, asynchronously: all registers = 0, all pending = 0, FSM = IDLE, ptr = 0, busy = 0, all rd = 0, all rv = 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; after release, the FSM SHALL be IDLE with busy = 0.
REQ-031 Normal operation SHALL resume on the first rising clk edge after rst goes high.

Verification
REQ-032 Write r5=0xDEADBEEF via we0; next cycle read r5 on all 4 ports -> rd=0xDEADBEEF, rv=1 on each port.
REQ-033 we0 (r7, 0x11) and we1 (r7, 0x22) in the same cycle; in that cycle read r7 -> 0x22 (bypass); next cycle -> 0x22 from the array.
REQ-034 Reserve r3; read r3 -> rv=0 with old data; then we1 r3=0x55 -> rv=1, rd=0x55 in the write cycle and after.
REQ-035 Reserve and write r9 in the same cycle -> next cycle rd=written data, rv=0.
REQ-036 Fill r1..r31, pulse clr_req -> busy high 31 cycles, rd=0 and rv=0 throughout; a write attempted mid-sweep is lost; afterwards all reads = 0 with rv=1.
REQ-037 Pull rst low at sweep cycle 10 -> busy=0 and all outputs 0 immediately; after release, reads return 0 and rv=1, and a new write succeeds.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports with
// write bypass, per-register pending (scoreboard) bits and a sequential clear sweep.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rv,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]    pending_q;
  logic [DEPTH-1:0]    pending_d;

  logic sweep;
  logic wr0_en;
  logic wr1_en;

  assign sweep  = (state_q == SWEEP);
  assign wr0_en = !sweep && we0 && (wa0 != '0);
  assign wr1_en = !sweep && we1 && (wa1 != '0);
  assign busy   = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= SWEEP;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reserve is applied after the write clears so a same-address reserve wins.
  always_comb begin
    pending_d = pending_q;
    if (sweep) begin
      pending_d[ptr_q] = 1'b0;
    end else begin
      if (wr0_en) pending_d[wa0] = 1'b0;
      if (wr1_en) pending_d[wa1] = 1'b0;
      if (rsv_en && (rsv_addr != '0)) pending_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else if (sweep) begin
      regs_q[ptr_q] <= '0;
    end else begin
      if (wr0_en) regs_q[wa0] <= wd0;
      if (wr1_en) regs_q[wa1] <= wd1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra_i;
    rd   = '0;
    rv   = '0;
    ra_i = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra_i = ra[i*ADDR_W +: ADDR_W];
      if (rst && !busy_q && re[i]) begin
        if (ra_i == '0) begin
          rv[i] = 1'b1;
        end else if (wr1_en && (wa1 == ra_i)) begin
          rd[i*DATA_W +: DATA_W] = wd1;
          rv[i]                  = 1'b1;
        end else if (wr0_en && (wa0 == ra_i)) begin
          rd[i*DATA_W +: DATA_W] = wd0;
          rv[i]                  = 1'b1;
        end else begin
          rd[i*DATA_W +: DATA_W] = regs_q[ra_i];
          rv[i]                  = ~pending_q[ra_i];
        end
      end
    end
  end

endmodule
